// File: rtl/iob_fpga_rst_seq_pkg.sv
// Shared types and sizing helpers for the FPGA reset sequencer.
// State encoding, cause-bit positions and counter width functions.
package iob_fpga_rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam int CAUSE_POR  = 0;
  localparam int CAUSE_SW   = 1;
  localparam int CAUSE_SRC0 = 2;

  // Bits needed to hold values 0..m inclusive.
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iob_fpga_rst_seq_if.sv
// Board/PS-facing request inputs and staged reset outputs of the reset sequencer.
interface iob_fpga_rst_seq_if #(
  parameter int N_SRC = 2,
  parameter int N_OUT = 3
);

  logic             cke_i;
  logic [N_SRC-1:0] rst_src_i;
  logic             sw_rst_i;
  logic             cause_clr_i;
  logic [N_OUT-1:0] rst_o;
  logic             cke_o;
  logic             done_o;
  logic [N_SRC+1:0] cause_o;

  modport master (
    output cke_i, rst_src_i, sw_rst_i, cause_clr_i,
    input  rst_o, cke_o, done_o, cause_o
  );

  modport slave (
    input  cke_i, rst_src_i, sw_rst_i, cause_clr_i,
    output rst_o, cke_o, done_o, cause_o
  );

endinterface

// File: rtl/iob_fpga_rst_deb.sv
// One asynchronous reset request: 2-FF synchroniser plus consecutive-high debounce counter.
// req_o rises DEB_CYC+2 edges after the pin rises and drops as soon as the synced level is low.
module iob_fpga_rst_deb
  import iob_fpga_rst_seq_pkg::*;
#(
  parameter int DEB_CYC = 16
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic cke_i,
  input  logic src_i,
  output logic req_o
);

  localparam int             CW   = cnt_w(DEB_CYC);
  localparam logic [CW-1:0]  CMAX = CW'(DEB_CYC);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The synchroniser runs regardless of cke_i; only the counter is frozen.
  always_comb begin
    sync1_d = src_i;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (cke_i) begin
      if (!sync2_q) begin
        cnt_d = '0;
      end else if (cnt_q != CMAX) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_o = sync2_q && (cnt_q == CMAX);

endmodule

// File: rtl/iob_fpga_rst_seq.sv
// Reset sequencer: merges POR, debounced board requests and SW reset into N_OUT staged resets.
// rst_o[k] releases HOLD_CYC + k*STAGE_CYC enabled cycles after the last request; any request restarts.
module iob_fpga_rst_seq
  import iob_fpga_rst_seq_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int N_OUT     = 3,
  parameter int DEB_CYC   = 16,
  parameter int HOLD_CYC  = 8,
  parameter int STAGE_CYC = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  iob_fpga_rst_seq_if.slave io
);

  localparam int                CNT_W     = cnt_w(max_i(HOLD_CYC, STAGE_CYC));
  localparam int                STG_W     = cnt_w(N_OUT);
  localparam int                CAU_W     = N_SRC + 2;
  localparam logic [CNT_W-1:0]  HOLD_LD   = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]  STAGE_LD  = CNT_W'(STAGE_CYC);
  localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_OUT - 1);
  localparam logic [CAU_W-1:0]  CAUSE_RST = CAU_W'(1) << CAUSE_POR;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [N_OUT-1:0] rst_q, rst_d;
  logic [CAU_W-1:0] cause_q, cause_d;
  logic [N_SRC-1:0] req;
  logic             req_any;

  for (genvar k = 0; k < N_SRC; k++) begin : g_deb
    iob_fpga_rst_deb #(
      .DEB_CYC(DEB_CYC)
    ) u_deb (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .cke_i  (io.cke_i),
      .src_i  (io.rst_src_i[k]),
      .req_o  (req[k])
    );
  end

  assign req_any = (|req) | io.sw_rst_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ASSERT;
      cnt_q   <= HOLD_LD;
      stage_q <= '0;
      rst_q   <= '1;
      cause_q <= CAUSE_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
    end
  end

  // Releases shift a zero in from bit 0, so the lowest still-asserted output is always next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    if (io.cke_i) begin
      if (req_any) begin
        state_d = ASSERT;
        cnt_d   = HOLD_LD;
        stage_d = '0;
        rst_d   = '1;
      end else begin
        case (state_q)
          ASSERT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = STAGE_LD;
              stage_d = STG_W'(1);
              rst_d   = rst_q << 1;
              state_d = (N_OUT == 1) ? RUN : RELEASE;
            end
          end
          RELEASE: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = STAGE_LD;
              stage_d = stage_q + STG_W'(1);
              rst_d   = rst_q << 1;
              if (stage_q == STG_LAST) begin
                state_d = RUN;
              end
            end
          end
          RUN: begin
            state_d = RUN;
          end
          default: begin
            state_d = ASSERT;
            cnt_d   = HOLD_LD;
            rst_d   = '1;
          end
        endcase
      end
    end
  end

  // Set wins over clear so a request coinciding with cause_clr_i is never lost.
  always_comb begin
    cause_d = cause_q;
    if (io.cke_i) begin
      if (io.cause_clr_i) begin
        cause_d = '0;
      end
      cause_d[CAUSE_SW]            = cause_d[CAUSE_SW] | io.sw_rst_i;
      cause_d[CAUSE_SRC0 +: N_SRC] = cause_d[CAUSE_SRC0 +: N_SRC] | req;
    end
  end

  always_comb begin
    io.rst_o   = rst_q;
    io.done_o  = (state_q == RUN);
    io.cke_o   = (state_q == RUN);
    io.cause_o = cause_q;
  end

endmodule
